reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared register.
// Each transaction runs IDLE -> GRANT -> WRITE, and every output comes from a register.
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_ena,
    output logic [WIDTH-1:0]      reg_data,
    output logic                  busy,
    output logic [7:0]            wr_count
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] reg_data_q, reg_data_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             reg_ena_q, reg_ena_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;

    // Scan from the far end back to ptr, so the last hit is the first in search order.
    always_comb begin : rr_search
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req[PW'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        hold_d     = hold_q;
        reg_data_d = reg_data_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        reg_ena_d  = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    win_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    hold_d  = data_in[pick_idx*WIDTH +: WIDTH];
                end
            end
            GRANT: begin
                // A requester that drops out before the write forfeits its turn, ptr untouched.
                if (req[win_q]) begin
                    state_d    = WRITE;
                    reg_ena_d  = 1'b1;
                    reg_data_d = hold_q;
                    ack_d      = gnt_q;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            WRITE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = PW'((int'(win_q) + 1) % NREQ);
                cnt_d   = cnt_q + 8'd1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            hold_q     <= '0;
            reg_data_q <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            reg_ena_q  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            hold_q     <= hold_d;
            reg_data_q <= reg_data_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            reg_ena_q  <= reg_ena_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign reg_ena  = reg_ena_q;
    assign reg_data = reg_data_q;
    assign busy     = busy_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_reg_write_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        reg_ena;
    logic [7:0]  reg_data;
    logic        busy;
    logic [7:0]  wr_count;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int m_cnt = 0;

    reg_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .ack(ack), .reg_ena(reg_ena), .reg_data(reg_data),
        .busy(busy), .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        req = 4'b0000;
        step();
        step();
        rst   = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req     = 4'b1111;
        data_in = $urandom;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (gnt !== 4'b0000 || ack !== 4'b0000 || reg_ena !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctl c=%0d gnt=%b ack=%b ena=%b busy=%b exp all 0", c, gnt, ack, reg_ena, busy);
            end
            total++;
            if (reg_data !== 8'h00 || wr_count !== 8'd0) begin
                bad++;
                $display("FAIL reset_data c=%0d reg_data=%h wr_count=%0d exp 00/0", c, reg_data, wr_count);
            end
        end
        rst   = 1'b1;
        req   = 4'b0000;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_single();
        req     = 4'b0100;
        data_in = 32'h0053_0000;
        step();
        total++;
        if (gnt !== 4'b0100 || reg_ena !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant gnt=%b ena=%b ack=%b busy=%b exp 0100/0/0000/1", gnt, reg_ena, ack, busy);
        end
        step();
        total++;
        if (reg_ena !== 1'b1 || reg_data !== 8'h53 || ack !== 4'b0100 || gnt !== 4'b0100) begin
            bad++;
            $display("FAIL single_write ena=%b data=%h ack=%b gnt=%b exp 1/53/0100/0100", reg_ena, reg_data, ack, gnt);
        end
        req = 4'b0000;
        step();
        m_ptr = 3;
        m_cnt = 1;
        total++;
        if (wr_count !== 8'd1 || reg_ena !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000 || reg_data !== 8'h53 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done cnt=%0d ena=%b gnt=%b ack=%b data=%h busy=%b exp 1/0/0000/0000/53/0",
                     wr_count, reg_ena, gnt, ack, reg_data, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] lanes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
        int nw;
        int phase;
        int w;
        do_reset();
        nw      = 0;
        req     = 4'b1111;
        data_in = 32'h4332_2110;
        for (int k = 1; k <= 15; k++) begin
            step();
            phase = (k - 1) % 3;
            w     = ((k - 1) / 3) % 4;
            if (reg_ena === 1'b1) nw++;
            total++;
            if (phase == 0 && (gnt !== 4'(1 << w) || reg_ena !== 1'b0 || busy !== 1'b1)) begin
                bad++;
                $display("FAIL rr_grant k=%0d gnt=%b ena=%b busy=%b exp gnt=%b", k, gnt, reg_ena, busy, 4'(1 << w));
            end else if (phase == 1 && (reg_ena !== 1'b1 || reg_data !== lanes[w] || ack !== 4'(1 << w))) begin
                bad++;
                $display("FAIL rr_write k=%0d ena=%b data=%h ack=%b exp 1/%h/%b", k, reg_ena, reg_data, ack, lanes[w], 4'(1 << w));
            end else if (phase == 2 && (gnt !== 4'b0000 || reg_ena !== 1'b0 || busy !== 1'b0 || wr_count !== 8'(k / 3))) begin
                bad++;
                $display("FAIL rr_idle k=%0d gnt=%b ena=%b busy=%b cnt=%0d exp cnt=%0d", k, gnt, reg_ena, busy, wr_count, k / 3);
            end
        end
        total++;
        if (wr_count !== 8'd5 || nw != 5) begin
            bad++;
            $display("FAIL rr_count wr_count=%0d writes=%0d exp 5/5", wr_count, nw);
        end
        req   = 4'b0000;
        m_ptr = 1;
        m_cnt = 5;
    endtask

    task automatic test_abort();
        do_reset();
        req     = 4'b0001;
        data_in = 32'h0000_00E7;
        step();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL abort_grant gnt=%b exp 0001", gnt);
        end
        req = 4'b0000;
        step();
        total++;
        if (gnt !== 4'b0000 || reg_ena !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || wr_count !== 8'd0) begin
            bad++;
            $display("FAIL abort_clear gnt=%b ena=%b ack=%b busy=%b cnt=%0d exp 0000/0/0000/0/0",
                     gnt, reg_ena, ack, busy, wr_count);
        end
        // From ptr=0 lane 0 wins over lane 3; an advanced ptr would pick lane 3.
        req     = 4'b1001;
        data_in = 32'h7700_0011;
        step();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL abort_ptr gnt=%b exp 0001", gnt);
        end
        step();
        total++;
        if (ack !== 4'b0001 || reg_data !== 8'h11 || reg_ena !== 1'b1) begin
            bad++;
            $display("FAIL abort_next ack=%b data=%h ena=%b exp 0001/11/1", ack, reg_data, reg_ena);
        end
        req = 4'b0000;
        step();
        m_ptr = 1;
        m_cnt = 1;
    endtask

    task automatic test_data_stable();
        do_reset();
        req     = 4'b0010;
        data_in = 32'h0000_AA00;
        step();
        data_in = 32'h0000_5500;
        step();
        total++;
        if (reg_ena !== 1'b1 || reg_data !== 8'hAA) begin
            bad++;
            $display("FAIL stable_write ena=%b data=%h exp 1/aa", reg_ena, reg_data);
        end
        req = 4'b0000;
        step();
        step();
        total++;
        if (reg_ena !== 1'b0 || reg_data !== 8'hAA) begin
            bad++;
            $display("FAIL stable_hold ena=%b data=%h exp 0/aa", reg_ena, reg_data);
        end
        m_ptr = 2;
        m_cnt = 1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req     = 4'b0100;
        data_in = 32'h00C3_0000;
        step();
        step();
        total++;
        if (reg_ena !== 1'b1) begin
            bad++;
            $display("FAIL midrst_write ena=%b exp 1", reg_ena);
        end
        rst = 1'b0;
        step();
        total++;
        if (ack !== 4'b0000 || reg_ena !== 1'b0 || gnt !== 4'b0000 || reg_data !== 8'h00 || wr_count !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_zero ack=%b ena=%b gnt=%b data=%h cnt=%0d busy=%b exp all 0",
                     ack, reg_ena, gnt, reg_data, wr_count, busy);
        end
        rst   = 1'b1;
        req   = 4'b0000;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_random();
        logic [3:0]  r;
        logic [31:0] d;
        logic [7:0]  ed;
        logic [7:0]  last;
        int          w;
        bit          ab;
        bit          ch;
        do_reset();
        last = 8'h00;
        for (int t = 0; t < 40; t++) begin
            r  = 4'($urandom_range(1, 15));
            d  = $urandom;
            ab = ($urandom_range(0, 4) == 0);
            ch = 1'($urandom_range(0, 1));
            w  = rr_pick(r, m_ptr);
            ed = d[w*8 +: 8];
            req     = r;
            data_in = d;
            step();
            total++;
            if (gnt !== 4'(1 << w) || reg_ena !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL rnd_grant t=%0d gnt=%b ena=%b busy=%b exp gnt=%b", t, gnt, reg_ena, busy, 4'(1 << w));
            end
            if (ch) data_in = $urandom;
            // Extra requests raised in GRANT must not disturb the current winner.
            if (ab) req = r & ~4'(1 << w);
            else if (ch) req = r | 4'($urandom_range(0, 15));
            step();
            if (ab) begin
                total++;
                if (gnt !== 4'b0000 || reg_ena !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 ||
                    wr_count !== 8'(m_cnt) || reg_data !== last) begin
                    bad++;
                    $display("FAIL rnd_abort t=%0d gnt=%b ena=%b ack=%b busy=%b cnt=%0d data=%h exp cnt=%0d data=%h",
                             t, gnt, reg_ena, ack, busy, wr_count, reg_data, m_cnt, last);
                end
            end else begin
                total++;
                if (reg_ena !== 1'b1 || reg_data !== ed || ack !== 4'(1 << w) || gnt !== 4'(1 << w)) begin
                    bad++;
                    $display("FAIL rnd_write t=%0d ena=%b data=%h ack=%b gnt=%b exp 1/%h/%b",
                             t, reg_ena, reg_data, ack, gnt, ed, 4'(1 << w));
                end
                req = 4'b0000;
                step();
                m_ptr = (w + 1) % 4;
                m_cnt = (m_cnt + 1) % 256;
                last  = ed;
                total++;
                if (wr_count !== 8'(m_cnt) || gnt !== 4'b0000 || reg_ena !== 1'b0 || ack !== 4'b0000 ||
                    busy !== 1'b0 || reg_data !== last) begin
                    bad++;
                    $display("FAIL rnd_done t=%0d cnt=%0d gnt=%b ena=%b ack=%b busy=%b data=%h exp cnt=%0d data=%h",
                             t, wr_count, gnt, reg_ena, ack, busy, reg_data, m_cnt, last);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        int nw;
        do_reset();
        nw      = 0;
        req     = 4'b1111;
        data_in = $urandom;
        for (int k = 1; k <= 768; k++) begin
            step();
            if (reg_ena === 1'b1) nw++;
            if (k == 767) begin
                total++;
                if (wr_count !== 8'd255) begin
                    bad++;
                    $display("FAIL wrap_255 cnt=%0d exp 255", wr_count);
                end
            end
        end
        total++;
        if (wr_count !== 8'd0 || nw != 256) begin
            bad++;
            $display("FAIL wrap_zero cnt=%0d writes=%0d exp 0/256", wr_count, nw);
        end
        req = 4'b0000;
    endtask

    initial begin
        rst     = 1'b0;
        req     = 4'b0000;
        data_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_data_stable();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
